prog_loader: RTL and testbench

Serial program loader for the 1-bit processor: receives instruction bytes as a bit stream and writes them into a small program RAM that replaces the fixed program ROM, while holding the CPU in reset. It is the writing end of the instruction-fetch path. The counter-driven fetch side reads the same storage through a combinational read port.

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/prog_mem.sv | 33 +++
 rtl/prog_loader.sv | 127 ++++++++++++
 tb/tb_prog_loader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types for the serial program loader: FSM state encoding and byte geometry.
// PROG_LOADER_PARITY_EN widens the shift register so it can hold a whole byte while the parity bit arrives.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int BYTE_W = 8;

`ifdef PROG_LOADER_PARITY_EN
    localparam int SHIFT_W = BYTE_W;
`else
    localparam int SHIFT_W = BYTE_W - 1;
`endif

endpackage

// File: rtl/prog_mem.sv
// DEPTH x 8 program register file: synchronous write, combinational read, async active-low clear.
// Build option PROG_LOADER_PARITY_EN does not affect this module.
module prog_mem
    import prog_loader_pkg::*;
#(
    parameter int N = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [N-1:0]      i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [N-1:0]      i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** N;

    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: shifts MSB-first bytes into prog_mem while holding the CPU in reset.
// Define PROG_LOADER_PARITY_EN for 9-bit frames (8 data + even parity) with a PAR state.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic [N-1:0]      rd_addr,
    output logic [BYTE_W-1:0] rd_data,
    output logic              hold,
    output logic [N:0]        count,
    output logic              done,
    output logic              err
);

    state_t             r_state;
    logic [SHIFT_W-1:0] r_shift;
    logic [2:0]         r_bitcnt;
    logic [N:0]         r_count;
    logic               r_hold;
    logic               r_done;
    logic               r_err;

    logic               w_byte_end;
    logic               w_par_ok;
    logic               w_full;
    logic               w_we;
    logic [BYTE_W-1:0]  w_byte;

    // A byte completes on the last accepted bit of its frame; load low always wins.
    always_comb begin
`ifdef PROG_LOADER_PARITY_EN
        w_byte     = r_shift;
        w_par_ok   = ~(^r_shift ^ bit_in);
        w_byte_end = load && bit_valid && (r_state == PAR);
`else
        w_byte     = {r_shift, bit_in};
        w_par_ok   = 1'b1;
        w_byte_end = load && bit_valid && (r_state == DATA) && (r_bitcnt == 3'd7);
`endif
        w_full = r_count[N];
        w_we   = w_byte_end && !w_full && w_par_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_count  <= '0;
            r_hold   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_state  <= DATA;
                        r_hold   <= 1'b1;
                        r_count  <= '0;
                        r_err    <= 1'b0;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                    end
                end
                DATA, PAR: begin
                    if (!load) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        if ((r_bitcnt != 3'd0) || (r_state == PAR)) begin
                            r_err <= 1'b1;
                        end
                    end else if (bit_valid) begin
                        if (r_state == DATA) begin
                            r_shift  <= {r_shift[SHIFT_W-2:0], bit_in};
                            r_bitcnt <= r_bitcnt + 3'd1;
`ifdef PROG_LOADER_PARITY_EN
                            if (r_bitcnt == 3'd7) begin
                                r_state <= PAR;
                            end
                        end else begin
                            r_state <= DATA;
`endif
                        end
                        if (w_byte_end) begin
                            if (w_full || !w_par_ok) begin
                                r_err <= 1'b1;
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_hold  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    prog_mem #(.N(N)) u_mem (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_we    (w_we),
        .i_waddr (r_count[N-1:0]),
        .i_wdata (w_byte),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign hold  = r_hold;
    assign count = r_count;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (N=2); the parity steps are compiled in with PROG_LOADER_PARITY_EN.
`timescale 1ns/1ps
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic       hold;
    logic [2:0] count;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    prog_loader #(.N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .hold      (hold),
        .count     (count),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        rd_addr = 2'd0; #1; check({tag, "_m0"}, 32'(rd_data), 32'(e0));
        rd_addr = 2'd1; #1; check({tag, "_m1"}, 32'(rd_data), 32'(e1));
        rd_addr = 2'd2; #1; check({tag, "_m2"}, 32'(rd_data), 32'(e2));
        rd_addr = 2'd3; #1; check({tag, "_m3"}, 32'(rd_data), 32'(e3));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        for (int i = 7; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = b[i];
            cyc();
        end
`ifdef PROG_LOADER_PARITY_EN
        bit_valid = 1'b1;
        bit_in    = (^b) ^ bad_par;
        cyc();
`else
        if (bad_par) begin
            bit_valid = 1'b0;
        end
`endif
        bit_valid = 1'b0;
    endtask

    task automatic start_session();
        load = 1'b1;
        cyc();
    endtask

    task automatic end_session(input string tag);
        load = 1'b0;
        cyc();
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_hold_in_done"}, 32'(hold), 32'd1);
        cyc();
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_hold_low"}, 32'(hold), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_hold", 32'(hold), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_mem("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        cyc();
        rst = 1'b1;
        cyc();

        // Four bytes back-to-back
        start_session();
        check("s1_hold_up", 32'(hold), 32'd1);
        check("s1_count0", 32'(count), 32'd0);
        send_byte(8'hA5, 1'b0);
        rd_addr = 2'd0;
        #1;
        check("s1_write_latency", 32'(rd_data), 32'hA5);
        check("s1_count1", 32'(count), 32'd1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0);
        check("s1_count4", 32'(count), 32'd4);
        end_session("s1");
        check("s1_err", 32'(err), 32'd0);
        check("s1_count_kept", 32'(count), 32'd4);
        check_mem("s1", 8'hA5, 8'h3C, 8'hFF, 8'h01);

        // Overflow: fifth byte discarded
        start_session();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("ov_err_before", 32'(err), 32'd0);
        send_byte(8'h55, 1'b0);
        check("ov_count", 32'(count), 32'd4);
        check("ov_err", 32'(err), 32'd1);
        end_session("ov");
        check("ov_err_sticky", 32'(err), 32'd1);
        check_mem("ov", 8'h11, 8'h22, 8'h33, 8'h44);

        // Partial byte abort; err cleared at start
        start_session();
        check("pa_err_cleared", 32'(err), 32'd0);
        check("pa_count_cleared", 32'(count), 32'd0);
        send_byte(8'h12, 1'b0);
        for (int i = 7; i >= 5; i--) begin
            bit_valid = 1'b1;
            bit_in    = 1'b0 ^ (i[0]);
            cyc();
        end
        bit_valid = 1'b0;
        load = 1'b0;
        cyc();
        check("pa_done_pulse", 32'(done), 32'd1);
        check("pa_err", 32'(err), 32'd1);
        check("pa_count", 32'(count), 32'd1);
        check_mem("pa", 8'h12, 8'h22, 8'h33, 8'h44);

        // load re-asserted during DONE: start from IDLE one cycle later
        load = 1'b1;
        cyc();
        check("re_idle_hold", 32'(hold), 32'd0);
        check("re_idle_done", 32'(done), 32'd0);
        cyc();
        check("re_hold_up", 32'(hold), 32'd1);
        check("re_err_cleared", 32'(err), 32'd0);
        check("re_count_cleared", 32'(count), 32'd0);
        end_session("re");
        check("re_err_clean_end", 32'(err), 32'd0);

`ifdef PROG_LOADER_PARITY_EN
        // Wrong parity rejected, correct parity accepted next session
        start_session();
        send_byte(8'hA5, 1'b1);
        check("par_bad_count", 32'(count), 32'd0);
        check("par_bad_err", 32'(err), 32'd1);
        end_session("parb");
        check_mem("parb", 8'h12, 8'h22, 8'h33, 8'h44);
        start_session();
        check("par_err_cleared", 32'(err), 32'd0);
        send_byte(8'hA5, 1'b0);
        check("par_good_count", 32'(count), 32'd1);
        check("par_good_err", 32'(err), 32'd0);
        end_session("parg");
        check_mem("parg", 8'hA5, 8'h22, 8'h33, 8'h44);
`endif

        // Reset mid-byte
        start_session();
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            cyc();
        end
        bit_valid = 1'b0;
        check("mr_pre_hold", 32'(hold), 32'd1);
        rst = 1'b0;
        #1;
        check("mr_hold", 32'(hold), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_count", 32'(count), 32'd0);
        check_mem("mr", 8'h00, 8'h00, 8'h00, 8'h00);
        load = 1'b0;
        cyc();
        check("mr_done_after", 32'(done), 32'd0);
        rst = 1'b1;
        cyc();
        check("mr_hold_after", 32'(hold), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
